ace_snoop_responder: RTL

Snoop responder for a cached ACE master: the receiving end of the AC/CR/CD snoop channels driven by the CCU. It accepts one AC snoop at a time and looks up the line in the local tag array. It returns a CR response, then streams the cache line on CD from the data array. Finally it issues the resulting coherence-state update (invalidate, clean, make shared). It sits between the CCU snoop crossbar and the L1 tag/data arrays.

---
 rtl/ace_snoop_if.sv | 28 ++
 rtl/ace_snoop_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_if.sv
// AC/CR/CD snoop channels between the CCU snoop crossbar and a cached ACE master.
// The master modport is the CCU side; the slave modport is the snoop responder.
interface ace_snoop_if #(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 64
);
    logic                 ac_valid;
    logic                 ac_ready;
    logic [AddrWidth-1:0] ac_addr;
    logic [3:0]           ac_snoop;
    logic                 cr_valid;
    logic                 cr_ready;
    logic [4:0]           cr_resp;
    logic                 cd_valid;
    logic                 cd_ready;
    logic [DataWidth-1:0] cd_data;
    logic                 cd_last;

    modport master (
        output ac_valid, ac_addr, ac_snoop, cr_ready, cd_ready,
        input  ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
    );

    modport slave (
        input  ac_valid, ac_addr, ac_snoop, cr_ready, cd_ready,
        output ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
    );
endinterface

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: one snoop at a time, tag lookup, CR response, in-order CD
// line stream from the data array, then the resulting coherence-state update.
module ace_snoop_responder #(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 64,
    parameter int LineBeats = 4,
    parameter int WayWidth  = 2,
    localparam int BeatW    = $clog2(LineBeats),
    localparam int OffW     = $clog2(LineBeats * DataWidth / 8)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ace_snoop_if.slave           snp,
    output logic                 lookup_valid_o,
    input  logic                 lookup_ready_i,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_rsp_valid_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_unique_i,
    input  logic                 lookup_dirty_i,
    input  logic [WayWidth-1:0]  lookup_way_i,
    output logic                 rd_en_o,
    output logic [WayWidth-1:0]  rd_way_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic [BeatW-1:0]     rd_beat_o,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic [WayWidth-1:0]  upd_way_o,
    output logic [AddrWidth-1:0] upd_addr_o,
    output logic                 upd_invalidate_o,
    output logic                 upd_clean_o,
    output logic                 upd_shared_o
);
    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, DATA, UPDATE} state_t;

    state_t               state_reg;
    logic                 ready_en_reg;
    logic [3:0]           snoop_reg;
    logic [AddrWidth-1:0] addr_reg;
    logic [WayWidth-1:0]  way_reg;
    logic                 lookup_valid_reg;
    logic                 cr_valid_reg;
    logic [4:0]           cr_resp_reg;
    logic                 inv_reg, clean_reg, shared_reg;
    logic                 upd_valid_reg;
    logic [BeatW:0]       req_cnt_reg;
    logic [BeatW-1:0]     sent_cnt_reg;
    logic                 pend_reg;
    logic                 hold_valid_reg;
    logic [DataWidth-1:0] hold_data_reg;

    logic                 ac_hs, cd_present, cd_hs, op_supported;
    logic [4:0]           dec_resp;
    logic                 dec_inv, dec_clean, dec_shared;

    assign ac_hs      = snp.ac_valid && snp.ac_ready;
    // A beat is presented either straight from the array (pend) or from the hold register after a stall.
    assign cd_present = pend_reg || hold_valid_reg;
    assign cd_hs      = cd_present && snp.cd_ready;

    assign snp.ac_ready = (state_reg == IDLE) && ready_en_reg;
    assign snp.cr_valid = cr_valid_reg;
    assign snp.cr_resp  = cr_resp_reg;
    assign snp.cd_valid = cd_present;
    assign snp.cd_data  = hold_valid_reg ? hold_data_reg : (pend_reg ? rd_data_i : '0);
    assign snp.cd_last  = cd_present && (sent_cnt_reg == BeatW'(LineBeats - 1));

    assign lookup_valid_o   = lookup_valid_reg;
    assign lookup_addr_o    = addr_reg;
    assign rd_en_o          = (state_reg == DATA) && (req_cnt_reg < (BeatW + 1)'(LineBeats))
                              && (!cd_present || cd_hs);
    assign rd_way_o         = way_reg;
    assign rd_addr_o        = addr_reg;
    assign rd_beat_o        = req_cnt_reg[BeatW-1:0];
    assign upd_valid_o      = upd_valid_reg;
    assign upd_way_o        = way_reg;
    assign upd_addr_o       = addr_reg;
    assign upd_invalidate_o = inv_reg;
    assign upd_clean_o      = clean_reg;
    assign upd_shared_o     = shared_reg;

    always_comb begin
        case (snp.ac_snoop)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111,
            4'b1000, 4'b1001, 4'b1101: op_supported = 1'b1;
            default:                   op_supported = 1'b0;
        endcase
    end

    // Response bits are {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
    always_comb begin
        dec_resp   = '0;
        dec_inv    = 1'b0;
        dec_clean  = 1'b0;
        dec_shared = 1'b0;
        if (lookup_hit_i) begin
            case (snoop_reg)
                4'b0000: dec_resp = {lookup_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
                4'b0001, 4'b0010, 4'b0011: begin
                    dec_resp   = {lookup_unique_i, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
                    dec_shared = 1'b1;
                    dec_clean  = lookup_dirty_i;
                end
                4'b0111: begin
                    dec_resp = {lookup_unique_i, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
                    dec_inv  = 1'b1;
                end
                4'b1000: begin
                    dec_resp  = {lookup_unique_i, 1'b1, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    dec_clean = lookup_dirty_i;
                end
                4'b1001: begin
                    dec_resp = {lookup_unique_i, 1'b0, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    dec_inv  = 1'b1;
                end
                4'b1101: dec_inv = 1'b1;
                default: dec_resp = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= IDLE;
            ready_en_reg     <= 1'b0;
            snoop_reg        <= '0;
            addr_reg         <= '0;
            way_reg          <= '0;
            lookup_valid_reg <= 1'b0;
            cr_valid_reg     <= 1'b0;
            cr_resp_reg      <= '0;
            inv_reg          <= 1'b0;
            clean_reg        <= 1'b0;
            shared_reg       <= 1'b0;
            upd_valid_reg    <= 1'b0;
            req_cnt_reg      <= '0;
            sent_cnt_reg     <= '0;
            pend_reg         <= 1'b0;
            hold_valid_reg   <= 1'b0;
            hold_data_reg    <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (ac_hs) begin
                        snoop_reg <= snp.ac_snoop;
                        addr_reg  <= {snp.ac_addr[AddrWidth-1:OffW], {OffW{1'b0}}};
                        if (op_supported) begin
                            lookup_valid_reg <= 1'b1;
                            state_reg        <= LOOKUP;
                        end else begin
                            cr_valid_reg <= 1'b1;
                            cr_resp_reg  <= '0;
                            inv_reg      <= 1'b0;
                            clean_reg    <= 1'b0;
                            shared_reg   <= 1'b0;
                            state_reg    <= RESP;
                        end
                    end
                end
                LOOKUP: begin
                    if (lookup_valid_reg && lookup_ready_i) begin
                        lookup_valid_reg <= 1'b0;
                    end
                    if (lookup_rsp_valid_i && (!lookup_valid_reg || lookup_ready_i)) begin
                        way_reg      <= lookup_way_i;
                        cr_resp_reg  <= dec_resp;
                        inv_reg      <= dec_inv;
                        clean_reg    <= dec_clean;
                        shared_reg   <= dec_shared;
                        cr_valid_reg <= 1'b1;
                        state_reg    <= RESP;
                    end
                end
                RESP: begin
                    if (snp.cr_ready) begin
                        cr_valid_reg <= 1'b0;
                        if (cr_resp_reg[0]) begin
                            req_cnt_reg    <= '0;
                            sent_cnt_reg   <= '0;
                            pend_reg       <= 1'b0;
                            hold_valid_reg <= 1'b0;
                            state_reg      <= DATA;
                        end else if (inv_reg || clean_reg || shared_reg) begin
                            upd_valid_reg <= 1'b1;
                            state_reg     <= UPDATE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                DATA: begin
                    pend_reg    <= rd_en_o;
                    req_cnt_reg <= req_cnt_reg + (BeatW + 1)'(rd_en_o);
                    // Array data is only valid for one cycle, so a stalled beat is parked in the hold register.
                    if (pend_reg && !cd_hs) begin
                        hold_valid_reg <= 1'b1;
                        hold_data_reg  <= rd_data_i;
                    end else if (cd_hs) begin
                        hold_valid_reg <= 1'b0;
                    end
                    if (cd_hs) begin
                        sent_cnt_reg <= sent_cnt_reg + 1'b1;
                        if (snp.cd_last) begin
                            if (inv_reg || clean_reg || shared_reg) begin
                                upd_valid_reg <= 1'b1;
                                state_reg     <= UPDATE;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end
                UPDATE: begin
                    if (upd_ready_i) begin
                        upd_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
